// File: rtl/axi_sched_pkg.sv
// rtl/axi_sched_pkg.sv - shared state type and round-robin pick helper for the write scheduler
package axi_sched_pkg;

  // Upper bound on arbitrated ports; the pick helper works on a fixed-width request vector.
  localparam int RR_MAX_PORTS = 32;
  localparam int RR_IDX_W     = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

  // First requester at or after ptr, wrapping over n ports; returns ptr when nobody requests.
  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [RR_MAX_PORTS-1:0] req,
    input logic [RR_IDX_W-1:0]     ptr,
    input int                      n
  );
    logic found;
    int   j;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < RR_MAX_PORTS; i++) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (!found && req[j[RR_IDX_W-1:0]]) begin
          rr_pick = j[RR_IDX_W-1:0];
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/axi_sched_rr_arb.sv
// rtl/axi_sched_rr_arb.sv - registered round-robin AW arbiter holding its grant until acknowledged
module axi_sched_rr_arb
  import axi_sched_pkg::*;
#(
  parameter int  N  = 2,
  localparam int CL = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  input  logic          i_ack,
  output logic          o_valid,
  output logic [CL-1:0] o_grant_idx
);

  sched_state_t  r_state;
  logic [CL-1:0] r_ptr;
  logic [CL-1:0] r_idx;
  logic          r_valid;
  logic [CL-1:0] w_pick;
  logic [CL-1:0] w_next_ptr;

  assign w_pick      = CL'(rr_pick(RR_MAX_PORTS'(i_req), RR_IDX_W'(r_ptr), N));
  assign w_next_ptr  = (r_idx == CL'(N - 1)) ? '0 : r_idx + CL'(1);
  assign o_valid     = r_valid;
  assign o_grant_idx = r_idx;

  // Grant FSM: latch a winner in IDLE, hold it until the master accepts, then rotate priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_en && |i_req) begin
            r_idx   <= w_pick;
            r_valid <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (i_ack) begin
            r_ptr   <= w_next_ptr;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_sched.sv
// rtl/axi_wr_sched.sv - AW arbitration, AW-ordered W routing and outstanding-burst cap for one master port
module axi_wr_sched
  import axi_sched_pkg::*;
#(
  parameter int  S_COUNT    = 2,
  parameter int  FIFO_DEPTH = 4,
  parameter int  MAX_OUTST  = 8,
  localparam int CL_S       = $clog2(S_COUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_COUNT-1:0] s_awvalid,
  output logic [S_COUNT-1:0] s_awready,
  output logic               m_awvalid,
  input  logic               m_awready,
  output logic [CL_S-1:0]    aw_sel,
  input  logic [S_COUNT-1:0] s_wvalid,
  input  logic [S_COUNT-1:0] s_wlast,
  output logic [S_COUNT-1:0] s_wready,
  output logic               m_wvalid,
  input  logic               m_wready,
  output logic [CL_S-1:0]    w_sel,
  input  logic               m_bhs,
  output logic [7:0]         outst_cnt,
  output logic               err_b_unf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CL_S-1:0] r_fifo [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_cnt;
  logic [7:0]      r_outst;
  logic            r_err;

  logic            w_grant_en;
  logic            w_aw_hs;
  logic            w_empty;
  logic            w_pop;

  // New grants only when the order FIFO has room and the B budget is not exhausted.
  assign w_empty    = (r_cnt == '0);
  assign w_grant_en = (r_cnt < (AW+1)'(FIFO_DEPTH)) && (r_outst < 8'(MAX_OUTST));
  assign w_aw_hs    = m_awvalid && m_awready;

  axi_sched_rr_arb #(
    .N (S_COUNT)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (s_awvalid),
    .i_en        (w_grant_en),
    .i_ack       (m_awready),
    .o_valid     (m_awvalid),
    .o_grant_idx (aw_sel)
  );

  // W mux follows the oldest accepted AW; an empty FIFO parks the select at port 0.
  assign w_sel     = w_empty ? '0 : r_fifo[r_rd_ptr];
  assign m_wvalid  = !w_empty && s_wvalid[w_sel];
  assign w_pop     = m_wvalid && m_wready && s_wlast[w_sel];
  assign outst_cnt = r_outst;
  assign err_b_unf = r_err;

  // Steer ready only to the granted AW port and the port owning the FIFO head.
  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    if (m_awvalid) s_awready[aw_sel] = m_awready;
    if (!w_empty)  s_wready[w_sel]   = m_wready;
  end

  // Order FIFO: push the granted port on AW handshake, pop on the head port's last W beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_aw_hs) begin
        r_fifo[r_wr_ptr] <= aw_sel;
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_aw_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Outstanding bursts: count AW handshakes against B handshakes; flag a B with nothing pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_outst <= 8'd0;
      r_err   <= 1'b0;
    end else if (w_aw_hs && !m_bhs) begin
      r_outst <= r_outst + 8'd1;
    end else if (m_bhs && !w_aw_hs) begin
      if (r_outst == 8'd0) r_err <= 1'b1;
      else                 r_outst <= r_outst - 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_wr_sched.sv
// tb/tb_axi_wr_sched.sv - scoreboard bench for the write-path scheduler
module tb_axi_wr_sched;

  localparam int S     = 2;
  localparam int DEPTH = 4;
  localparam int MAXO  = 6;
  localparam int CL    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [S-1:0]  s_awvalid;
  logic [S-1:0]  s_awready;
  logic          m_awvalid;
  logic          m_awready;
  logic [CL-1:0] aw_sel;
  logic [S-1:0]  s_wvalid;
  logic [S-1:0]  s_wlast;
  logic [S-1:0]  s_wready;
  logic          m_wvalid;
  logic          m_wready;
  logic [CL-1:0] w_sel;
  logic          m_bhs;
  logic [7:0]    outst_cnt;
  logic          err_b_unf;

  int n_cmp = 0;
  int n_bad = 0;
  int m_rr  = 0;
  int exp_aw[$];
  int exp_w[$];

  axi_wr_sched #(
    .S_COUNT    (S),
    .FIFO_DEPTH (DEPTH),
    .MAX_OUTST  (MAXO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .aw_sel    (aw_sel),
    .s_wvalid  (s_wvalid),
    .s_wlast   (s_wlast),
    .s_wready  (s_wready),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .w_sel     (w_sel),
    .m_bhs     (m_bhs),
    .outst_cnt (outst_cnt),
    .err_b_unf (err_b_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  function automatic int model_pick(input logic [S-1:0] req, input int ptr);
    for (int k = 0; k < S; k++) begin
      if (req[(ptr + k) % S]) return (ptr + k) % S;
    end
    return ptr;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_aw_hs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (m_awvalid && m_awready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; s_awvalid = '0; m_awready = 1'b0; s_wvalid = '0;
    s_wlast = '0; m_wready = 1'b0; m_bhs = 1'b0;
    step();
    step();
    rst = 1'b1;
    m_rr = 0;
    exp_aw.delete();
    exp_w.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; s_awvalid = '1; m_awready = 1'b0; s_wvalid = '0;
    s_wlast = '0; m_wready = 1'b0; m_bhs = 1'b0;
    step();
    step();
    n_cmp++; if ({m_awvalid, s_awready, aw_sel} !== '0) begin n_bad++; $display("FAIL reset_aw got %b want 0", {m_awvalid, s_awready, aw_sel}); end
    n_cmp++; if ({m_wvalid, s_wready, w_sel} !== '0) begin n_bad++; $display("FAIL reset_w got %b want 0", {m_wvalid, s_wready, w_sel}); end
    n_cmp++; if ({outst_cnt, err_b_unf} !== '0) begin n_bad++; $display("FAIL reset_cnt got %b want 0", {outst_cnt, err_b_unf}); end
    rst = 1'b1;
    m_rr = 0;
    step();
    n_cmp++; if (m_awvalid !== 1'b1) begin n_bad++; $display("FAIL reset_first_grant got %b want 1", m_awvalid); end
    n_cmp++; if (aw_sel !== '0) begin n_bad++; $display("FAIL reset_first_sel got %0d want 0", aw_sel); end
    n_cmp++; if (s_awready !== '0) begin n_bad++; $display("FAIL reset_awready_held got %b want 00", s_awready); end
  endtask

  task automatic test_fairness();
    int e;
    bit ok;
    logic [S-1:0] oh;
    m_awready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_aw.push_back(model_pick(s_awvalid, m_rr));
      wait_aw_hs(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL fair_timeout got no handshake want handshake %0d", k); end
      e = exp_aw.pop_front();
      oh = '0; oh[e] = 1'b1;
      n_cmp++; if (aw_sel !== CL'(e)) begin n_bad++; $display("FAIL fair_aw_sel got %0d want %0d", aw_sel, e); end
      n_cmp++; if (s_awready !== oh) begin n_bad++; $display("FAIL fair_awready got %b want %b", s_awready, oh); end
      exp_w.push_back(e);
      m_rr = (e + 1) % S;
      step();
      n_cmp++; if (m_awvalid !== 1'b0) begin n_bad++; $display("FAIL fair_no_b2b got %b want 0", m_awvalid); end
    end
  endtask

  task automatic test_fifo_full();
    int e;
    bit ok;
    bit seen;
    logic [S-1:0] oh;
    m_awready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (m_awvalid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL full_stall got awvalid=1 want 0"); end
    n_cmp++; if (outst_cnt !== 8'd4) begin n_bad++; $display("FAIL full_outst got %0d want 4", outst_cnt); end
    e = exp_w.pop_front();
    n_cmp++; if (w_sel !== CL'(e)) begin n_bad++; $display("FAIL full_w_sel got %0d want %0d", w_sel, e); end
    oh = '0; oh[e] = 1'b1;
    s_wvalid = oh; s_wlast = oh; m_wready = 1'b1;
    #1;
    n_cmp++; if (m_wvalid !== 1'b1) begin n_bad++; $display("FAIL full_wvalid got %b want 1", m_wvalid); end
    n_cmp++; if (s_wready !== oh) begin n_bad++; $display("FAIL full_wready got %b want %b", s_wready, oh); end
    step();
    s_wvalid = '0; s_wlast = '0; m_wready = 1'b0;
    #1;
    n_cmp++; if (m_awvalid !== 1'b0) begin n_bad++; $display("FAIL full_early_grant got %b want 0", m_awvalid); end
    n_cmp++; if (w_sel !== CL'(exp_w[0])) begin n_bad++; $display("FAIL full_next_head got %0d want %0d", w_sel, exp_w[0]); end
    step();
    n_cmp++; if (m_awvalid !== 1'b1) begin n_bad++; $display("FAIL full_resume got %b want 1", m_awvalid); end
    exp_aw.push_back(model_pick(s_awvalid, m_rr));
    m_awready = 1'b1;
    wait_aw_hs(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_timeout got no handshake want handshake"); end
    e = exp_aw.pop_front();
    n_cmp++; if (aw_sel !== CL'(e)) begin n_bad++; $display("FAIL full_aw_sel got %0d want %0d", aw_sel, e); end
    exp_w.push_back(e);
    m_rr = (e + 1) % S;
    step();
    s_awvalid = '0; m_awready = 1'b0;
  endtask

  task automatic test_w_order();
    int e;
    bit ok;
    do_reset();
    s_wvalid = 2'b01; s_wlast = 2'b01; m_wready = 1'b1;
    #1;
    n_cmp++; if ({m_wvalid, s_wready} !== 3'b000) begin n_bad++; $display("FAIL word_early_beat got %b want 000", {m_wvalid, s_wready}); end
    m_awready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_awvalid = (k == 0) ? 2'b10 : 2'b01;
      exp_aw.push_back(model_pick(s_awvalid, m_rr));
      wait_aw_hs(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL word_timeout got no handshake want handshake %0d", k); end
      e = exp_aw.pop_front();
      n_cmp++; if (aw_sel !== CL'(e)) begin n_bad++; $display("FAIL word_aw_sel got %0d want %0d", aw_sel, e); end
      exp_w.push_back(e);
      m_rr = (e + 1) % S;
      step();
    end
    s_awvalid = '0; m_awready = 1'b0;
    #1;
    n_cmp++; if (w_sel !== CL'(exp_w[0])) begin n_bad++; $display("FAIL word_head got %0d want %0d", w_sel, exp_w[0]); end
    n_cmp++; if ({m_wvalid, s_wready[0]} !== 2'b00) begin n_bad++; $display("FAIL word_p0_stall got %b want 00", {m_wvalid, s_wready[0]}); end
    for (int b = 0; b < 4; b++) begin
      s_wvalid = 2'b11;
      s_wlast  = {(b == 3), 1'b1};
      #1;
      n_cmp++; if (w_sel !== CL'(exp_w[0])) begin n_bad++; $display("FAIL word_beat_sel got %0d want %0d", w_sel, exp_w[0]); end
      n_cmp++; if ({m_wvalid, s_wready} !== 3'b110) begin n_bad++; $display("FAIL word_beat_hs got %b want 110", {m_wvalid, s_wready}); end
      if (b == 3) void'(exp_w.pop_front());
      step();
    end
    #1;
    n_cmp++; if (w_sel !== CL'(exp_w[0])) begin n_bad++; $display("FAIL word_switch_sel got %0d want %0d", w_sel, exp_w[0]); end
    n_cmp++; if ({m_wvalid, s_wready} !== 3'b101) begin n_bad++; $display("FAIL word_switch_hs got %b want 101", {m_wvalid, s_wready}); end
    void'(exp_w.pop_front());
    step();
    s_wvalid = '0; s_wlast = '0;
    #1;
    n_cmp++; if ({m_wvalid, s_wready, w_sel} !== '0) begin n_bad++; $display("FAIL word_empty got %b want 0", {m_wvalid, s_wready, w_sel}); end
    m_wready = 1'b0;
  endtask

  task automatic test_outst_cap();
    int e;
    bit ok;
    bit seen;
    do_reset();
    s_wvalid = 2'b11; s_wlast = 2'b11; m_wready = 1'b1;
    s_awvalid = 2'b11; m_awready = 1'b1;
    for (int k = 0; k < MAXO; k++) begin
      exp_aw.push_back(model_pick(s_awvalid, m_rr));
      wait_aw_hs(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL cap_timeout got no handshake want handshake %0d", k); end
      e = exp_aw.pop_front();
      n_cmp++; if (aw_sel !== CL'(e)) begin n_bad++; $display("FAIL cap_aw_sel got %0d want %0d", aw_sel, e); end
      m_rr = (e + 1) % S;
      step();
    end
    n_cmp++; if (outst_cnt !== 8'(MAXO)) begin n_bad++; $display("FAIL cap_count got %0d want %0d", outst_cnt, MAXO); end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (m_awvalid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL cap_stall got awvalid=1 want 0"); end
    m_bhs = 1'b1;
    step();
    m_bhs = 1'b0;
    #1;
    n_cmp++; if (outst_cnt !== 8'(MAXO - 1)) begin n_bad++; $display("FAIL cap_b_dec got %0d want %0d", outst_cnt, MAXO - 1); end
    exp_aw.push_back(model_pick(s_awvalid, m_rr));
    wait_aw_hs(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL cap_resume got no handshake want handshake"); end
    e = exp_aw.pop_front();
    n_cmp++; if (aw_sel !== CL'(e)) begin n_bad++; $display("FAIL cap_resume_sel got %0d want %0d", aw_sel, e); end
    m_rr = (e + 1) % S;
    m_bhs = 1'b1;
    step();
    m_bhs = 1'b0;
    #1;
    n_cmp++; if (outst_cnt !== 8'(MAXO - 1)) begin n_bad++; $display("FAIL cap_coincident got %0d want %0d", outst_cnt, MAXO - 1); end
    s_awvalid = '0; m_awready = 1'b0; s_wvalid = '0; s_wlast = '0; m_wready = 1'b0;
  endtask

  task automatic test_err();
    do_reset();
    m_bhs = 1'b1;
    step();
    m_bhs = 1'b0;
    #1;
    n_cmp++; if (err_b_unf !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", err_b_unf); end
    n_cmp++; if (outst_cnt !== 8'd0) begin n_bad++; $display("FAIL err_hold_zero got %0d want 0", outst_cnt); end
    step();
    step();
    step();
    n_cmp++; if (err_b_unf !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err_b_unf); end
    rst = 1'b0;
    step();
    n_cmp++; if (err_b_unf !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", err_b_unf); end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_fifo_full();
    test_w_order();
    test_outst_cap();
    test_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
